// File: rtl/fft_pkg.sv
// Shared defaults and state type for the FFT frame assembler family.
// The inter-byte timeout is compiled in with the FRAME_TIMEOUT_EN macro.
package fft_pkg;

    localparam int DEFAULT_FFT_SIZE       = 16;
    localparam int DEFAULT_WORD_SIZE      = 16;
    localparam int DEFAULT_DATA_LENGTH    = 8;
    localparam int DEFAULT_FRACTION       = 8;
    localparam int DEFAULT_CLOCK_PER_BIT  = 868;
    // Four 10-bit UART character times of silence end a partial frame.
    localparam int DEFAULT_TIMEOUT_CYCLES = 40 * DEFAULT_CLOCK_PER_BIT;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } frame_state_t;

endpackage

// File: rtl/frame_idle_timer.sv
// Counts idle cycles of a partially collected frame and flags expiry.
// Only instantiated when FRAME_TIMEOUT_EN is defined.
module frame_idle_timer #(
    parameter int TIMEOUT_CYCLES = 34720
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_clear,
    output logic o_expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    // A byte arriving in the expiry cycle wins, so clear gates the expiry.
    assign o_expire = i_active && !i_clear && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || !i_active || o_expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/fft_frame_assembler.sv
// Collects UART bytes into a frame of fixed-point samples and holds it for a consumer.
// Define FRAME_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES idle cycles.
module fft_frame_assembler
    import fft_pkg::*;
#(
    parameter int FFT_SIZE       = DEFAULT_FFT_SIZE,
    parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
    parameter int DATA_LENGTH    = DEFAULT_DATA_LENGTH,
    parameter int FRACTION       = DEFAULT_FRACTION,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_LENGTH-1:0]        i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_frame_ack,
    output logic [FFT_SIZE*WORD_SIZE-1:0] o_samples,
    output logic                          o_frame_valid,
    output logic [$clog2(FFT_SIZE):0]     o_count,
    output logic                          o_overrun,
    output logic                          o_timeout
);

    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam int INT_W = WORD_SIZE - FRACTION;

    if ((INT_W < DATA_LENGTH) || (FFT_SIZE < 2) || (FFT_SIZE > 64) ||
        ((FFT_SIZE & (FFT_SIZE - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_config
        $error("fft_frame_assembler: illegal parameter combination");
    end

    frame_state_t         state;
    frame_state_t         state_next;
    logic [WORD_SIZE-1:0] samples [FFT_SIZE];
    logic                 accept;
    logic                 overrun_evt;
    logic                 timeout_evt;
    logic                 frame_done;
    logic [IDX_W-1:0]     wr_idx;

    // Sign-extend the byte to the integer field, then place it above the fraction.
    function automatic logic [WORD_SIZE-1:0] to_sample(input logic [DATA_LENGTH-1:0] b);
        logic signed [INT_W-1:0] ext;
        logic [WORD_SIZE-1:0]    wide;
        ext  = INT_W'(signed'(b));
        wide = WORD_SIZE'(ext);
        return wide << FRACTION;
    endfunction

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of process ordering.
        if (i_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            COLLECT: if (frame_done)  state_next = FULL;
            FULL:    if (i_frame_ack) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        o_frame_valid = 1'b0;
        accept        = 1'b0;
        overrun_evt   = 1'b0;
        wr_idx        = o_count[IDX_W-1:0];
        case (state)
            COLLECT: accept = i_byte_valid;
            FULL: begin
                o_frame_valid = 1'b1;
                accept        = i_byte_valid && i_frame_ack;
                overrun_evt   = i_byte_valid && !i_frame_ack;
                wr_idx        = '0;
            end
            default: ;
        endcase
        frame_done = accept && (state == COLLECT) && (o_count == CNT_W'(FFT_SIZE - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count   <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= overrun_evt;
            if (accept) begin
                o_count <= (state == FULL) ? CNT_W'(1) : o_count + CNT_W'(1);
            end else if ((state == FULL) && i_frame_ack) begin
                o_count <= '0;
            end else if (timeout_evt) begin
                o_count <= '0;
            end
        end
    end

    // NOTE: the sample store is reset because the frame output must read as
    // all-zero after reset; it is never cleared otherwise, so stale samples persist.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < FFT_SIZE; k++) begin
                samples[k] <= '0;
            end
        end else if (accept) begin
            samples[wr_idx] <= to_sample(i_byte);
        end
    end

    always_comb begin
        o_samples = '0;
        for (int k = 0; k < FFT_SIZE; k++) begin
            o_samples[k*WORD_SIZE +: WORD_SIZE] = samples[k];
        end
    end

`ifdef FRAME_TIMEOUT_EN
    logic idle_active;

    assign idle_active = (state == COLLECT) && (o_count != '0);

    frame_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_active(idle_active),
        .i_clear (i_byte_valid),
        .o_expire(timeout_evt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_evt;
        end
    end
`else
    assign timeout_evt = 1'b0;
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_assembler.sv
// Directed and scoreboard bench for fft_frame_assembler (FFT_SIZE=16, TIMEOUT_CYCLES=100).
// Timeout scenarios run when FRAME_TIMEOUT_EN is defined; otherwise partial frames must wait.
module tb_fft_frame_assembler;

    localparam int FFT_SIZE = 16;
    localparam int WORD_SIZE = 16;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int FW = FFT_SIZE * WORD_SIZE;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [7:0]    i_byte = '0;
    logic          i_byte_valid = 1'b0;
    logic          i_frame_ack = 1'b0;
    logic [FW-1:0] o_samples;
    logic          o_frame_valid;
    logic [4:0]    o_count;
    logic          o_overrun;
    logic          o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the assembler, updated as stimulus is driven.
    logic [15:0]   m_samples [FFT_SIZE];
    int            m_count = 0;
    bit            m_full = 0;
    int            m_idle = 0;
    logic [FW-1:0] frame_q [$];
    logic          prev_valid = 1'b0;

    fft_frame_assembler #(
        .FFT_SIZE      (FFT_SIZE),
        .WORD_SIZE     (WORD_SIZE),
        .DATA_LENGTH   (8),
        .FRACTION      (8),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_frame_ack  (i_frame_ack),
        .o_samples    (o_samples),
        .o_frame_valid(o_frame_valid),
        .o_count      (o_count),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 2000000", $time);
        $fatal(1);
    end

    function automatic logic [15:0] to_word(input logic [7:0] b);
        return {b, 8'h00};
    endfunction

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < FFT_SIZE; k++) f[k*16 +: 16] = m_samples[k];
        return f;
    endfunction

    // One clock cycle of stimulus; the model predicts and the outputs are checked after the edge.
    task automatic drive(input logic rst, input logic v, input logic [7:0] b, input logic ack);
        logic exp_ovr;
        logic exp_to;
        logic [FW-1:0] want_frame;
        i_rst = rst;
        i_byte_valid = v;
        i_byte = b;
        i_frame_ack = ack;
        exp_ovr = 1'b0;
        exp_to = 1'b0;
        if (rst) begin
            m_full = 0;
            m_count = 0;
            m_idle = 0;
            for (int k = 0; k < FFT_SIZE; k++) m_samples[k] = '0;
        end else begin
`ifdef FRAME_TIMEOUT_EN
            if (v || m_full || m_count == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYCLES) begin
                    m_idle = 0;
                    m_count = 0;
                    exp_to = 1'b1;
                end
            end
`endif
            if (v && (!m_full || ack)) begin
                if (m_full) begin
                    m_samples[0] = to_word(b);
                    m_count = 1;
                    m_full = 0;
                end else begin
                    m_samples[m_count] = to_word(b);
                    m_count++;
                    if (m_count == FFT_SIZE) begin
                        m_full = 1;
                        frame_q.push_back(model_frame());
                    end
                end
            end else if (m_full && ack) begin
                m_full = 0;
                m_count = 0;
            end else if (m_full && v) begin
                exp_ovr = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_byte_valid = 1'b0;
        i_frame_ack = 1'b0;
        n_checks++;
        if (o_count !== 5'(m_count)) begin
            n_errors++;
            $display("FAIL count: got %0d want %0d at %0t", o_count, m_count, $time);
        end
        n_checks++;
        if (o_frame_valid !== m_full) begin
            n_errors++;
            $display("FAIL frame_valid: got %b want %b at %0t", o_frame_valid, m_full, $time);
        end
        n_checks++;
        if (o_overrun !== exp_ovr) begin
            n_errors++;
            $display("FAIL overrun: got %b want %b at %0t", o_overrun, exp_ovr, $time);
        end
        n_checks++;
        if (o_timeout !== exp_to) begin
            n_errors++;
            $display("FAIL timeout: got %b want %b at %0t", o_timeout, exp_to, $time);
        end
        n_checks++;
        if (o_samples !== model_frame()) begin
            n_errors++;
            $display("FAIL samples: got %h want %h at %0t", o_samples, model_frame(), $time);
        end
        if (o_frame_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_checks++;
            if (frame_q.size() == 0) begin
                n_errors++;
                $display("FAIL frame_pop: got unexpected frame %h want none at %0t", o_samples, $time);
            end else begin
                want_frame = frame_q.pop_front();
                if (o_samples !== want_frame) begin
                    n_errors++;
                    $display("FAIL frame_pop: got %h want %h at %0t", o_samples, want_frame, $time);
                end
            end
        end
        prev_valid = o_frame_valid;
    endtask

    task automatic strobe(input logic [7:0] b);
        drive(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic ack();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h80, 1'b1);
        n_checks++;
        if (o_count !== 5'd0 || o_frame_valid !== 1'b0 || o_samples !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got count=%0d valid=%b samples=%h want 0 0 0",
                     o_count, o_frame_valid, o_samples);
        end
    endtask

    task automatic test_full_frame();
        for (int k = 0; k < FFT_SIZE - 1; k++) begin
            strobe(8'(k));
            n_checks++;
            if (o_frame_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL early_valid: got %b want 0 after strobe %0d", o_frame_valid, k);
            end
        end
        strobe(8'h0F);
        n_checks++;
        if (o_frame_valid !== 1'b1 || o_count !== 5'd16) begin
            n_errors++;
            $display("FAIL full_frame: got valid=%b count=%0d want 1 16", o_frame_valid, o_count);
        end
        for (int k = 0; k < FFT_SIZE; k++) begin
            n_checks++;
            if (o_samples[k*16 +: 16] !== (16'(k) << 8)) begin
                n_errors++;
                $display("FAIL sample_%0d: got %h want %h", k, o_samples[k*16 +: 16], 16'(k) << 8);
            end
        end
    endtask

    task automatic test_overrun();
        logic [FW-1:0] held;
        int pulses;
        held = o_samples;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            strobe(8'hA0 + 8'(i));
            if (o_overrun === 1'b1) pulses++;
            idle(1);
        end
        n_checks++;
        if (pulses != 3 || o_samples !== held || o_count !== 5'd16) begin
            n_errors++;
            $display("FAIL overrun_hold: got pulses=%0d count=%0d held=%b want 3 16 1",
                     pulses, o_count, o_samples === held);
        end
    endtask

    task automatic test_ack_with_strobe();
        drive(1'b0, 1'b1, 8'hFF, 1'b1);
        n_checks++;
        if (o_frame_valid !== 1'b0 || o_count !== 5'd1 || o_samples[15:0] !== 16'hFF00 ||
            o_overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_strobe: got valid=%b count=%0d s0=%h ovr=%b want 0 1 ff00 0",
                     o_frame_valid, o_count, o_samples[15:0], o_overrun);
        end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
        idle(TIMEOUT_CYCLES - 1);
        n_checks++;
        if (o_count !== 5'd5 || o_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_timeout: got count=%0d to=%b want 5 0", o_count, o_timeout);
        end
        idle(1);
        n_checks++;
        if (o_timeout !== 1'b1 || o_count !== 5'd0) begin
            n_errors++;
            $display("FAIL timeout_fire: got to=%b count=%0d want 1 0", o_timeout, o_count);
        end
        for (int k = 0; k < FFT_SIZE; k++) strobe(8'h40 + 8'(k));
        n_checks++;
        if (o_frame_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_after_timeout: got valid=%b want 1", o_frame_valid);
        end
        ack();
    endtask

    task automatic test_timeout_race();
        for (int i = 0; i < 3; i++) strobe(8'h20 + 8'(i));
        idle(TIMEOUT_CYCLES - 1);
        strobe(8'h7E);
        n_checks++;
        if (o_timeout !== 1'b0 || o_count !== 5'd4) begin
            n_errors++;
            $display("FAIL timeout_race: got to=%b count=%0d want 0 4", o_timeout, o_count);
        end
        for (int k = 4; k < FFT_SIZE; k++) strobe(8'(k));
        ack();
    endtask
`else
    task automatic test_no_timeout();
        for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
        idle(TIMEOUT_CYCLES + 50);
        n_checks++;
        if (o_count !== 5'd5 || o_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL partial_wait: got count=%0d to=%b want 5 0", o_count, o_timeout);
        end
        for (int k = 5; k < FFT_SIZE; k++) strobe(8'(k));
        ack();
    endtask
`endif

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 8; k++) strobe(8'hC0 + 8'(k));
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        n_checks++;
        if (o_count !== 5'd0 || o_samples !== '0 || o_overrun !== 1'b0 || o_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got count=%0d samples=%h ovr=%b to=%b want 0 0 0 0",
                     o_count, o_samples, o_overrun, o_timeout);
        end
        for (int k = 0; k < FFT_SIZE; k++) strobe(8'h80 + 8'(k));
        n_checks++;
        if (o_frame_valid !== 1'b1 || o_samples[15:0] !== 16'h8000) begin
            n_errors++;
            $display("FAIL frame_after_reset: got valid=%b s0=%h want 1 8000",
                     o_frame_valid, o_samples[15:0]);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FFT_SIZE; k++) begin
                if (f > 0 && k == 0) drive(1'b0, 1'b1, 8'($urandom), 1'b1);
                else drive(1'b0, 1'b1, 8'($urandom), 1'($urandom));
                if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 8'h00, 1'($urandom));
            end
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overrun();
        test_ack_with_strobe();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`else
        test_no_timeout();
`endif
        test_reset_mid_frame();
        test_back_to_back();
        n_checks++;
        if (frame_q.size() != 0) begin
            n_errors++;
            $display("FAIL frames_left: got %0d pending want 0", frame_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_assembler.md
FFT_FRAME_ASSEMBLER -- requirements
Module: fft_frame_assembler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  FFT_SIZE, 16, samples per frame (power of two, 2..64)
  WORD_SIZE, 16, output sample width
  DATA_LENGTH, 8, received byte width
  FRACTION, 8, fractional bits of output sample
  TIMEOUT_CYCLES, 34720, inter-byte idle limit in i_clk cycles
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  i_clk  in  1  sole clock, rising edge
  i_rst  in  1  reset, synchronous, active-high
  i_byte  in  DATA_LENGTH  received byte from UART receiver
  i_byte_valid  in  1  one-cycle strobe, i_byte valid
  i_frame_ack  in  1  consumer has taken the frame
  o_samples  out  FFT_SIZE*WORD_SIZE  frame; sample k at bits [k*WORD_SIZE +: WORD_SIZE]
  o_frame_valid  out  1  complete frame held
  o_count  out  clog2(FFT_SIZE)+1  samples collected in current frame
  o_overrun  out  1  one-cycle pulse, byte dropped
  o_timeout  out  1  one-cycle pulse, partial frame discarded
REQ-003 The block SHALL use one clock, i_clk, and a synchronous, active-high reset, i_rst.

Function
REQ-004 The block SHALL have two states: COLLECT and FULL.
REQ-005 In COLLECT, each i_byte_valid SHALL write sample[o_count] and increment o_count on the next edge.
REQ-006 Sample conversion SHALL sign-extend i_byte to WORD_SIZE-FRACTION bits and append FRACTION zero bits (0x80 -> 0x8000, 0x01 -> 0x0100 at defaults).
REQ-007 The block SHALL check WORD_SIZE-FRACTION >= DATA_LENGTH at elaboration and fail otherwise.
REQ-008 When the byte that makes o_count equal FFT_SIZE is written, the block SHALL enter FULL and assert o_frame_valid on the same edge, one cycle after the strobe.
REQ-009 In FULL, o_samples SHALL be held stable, and o_frame_valid SHALL stay high until i_frame_ack is sampled high.
REQ-010 In FULL, i_frame_ack SHALL cause the block to return to COLLECT, set o_count to 0 and deassert o_frame_valid on the next edge.
REQ-011 In FULL, an i_byte_valid without i_frame_ack SHALL drop the byte and pulse o_overrun for one cycle.
REQ-012 In FULL, i_frame_ack and i_byte_valid in the same cycle SHALL accept the byte as sample 0, set o_count to 1, and not pulse o_overrun.
REQ-013 In COLLECT, i_frame_ack SHALL be ignored.
REQ-014 Samples with index >= o_count SHALL keep their previous values; they are not cleared between frames.

Reset
REQ-015 i_rst SHALL dominate all other inputs in the same cycle.
REQ-016 On i_rst, the state SHALL be COLLECT, o_count 0, o_frame_valid 0, o_overrun 0, o_timeout 0, o_samples all-zero and the idle counter 0.
REQ-017 An i_rst asserted mid-frame or in FULL SHALL discard the frame without pulsing o_timeout or o_overrun.

Configuration
REQ-018 The macro FRAME_TIMEOUT_EN SHALL compile the inter-byte timeout in or out.
REQ-019 With FRAME_TIMEOUT_EN defined, an idle counter SHALL clear on each i_byte_valid and count while in COLLECT with o_count > 0.
REQ-020 With FRAME_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT_CYCLES, o_count SHALL be cleared and o_timeout pulsed for one cycle.
REQ-021 With FRAME_TIMEOUT_EN defined, an i_byte_valid in the same cycle as the timeout SHALL win: the byte is stored and no timeout occurs.
REQ-022 Without FRAME_TIMEOUT_EN, the idle counter SHALL be absent, o_timeout SHALL be tied to 0, and partial frames SHALL wait indefinitely.

Structure
REQ-023 Shared package fft_pkg SHALL hold the FFT_SIZE, WORD_SIZE, DATA_LENGTH, FRACTION and CLOCK_PER_BIT defaults and the state typedef (COLLECT, FULL).
REQ-024 The idle counter SHALL be one sub-module, frame_idle_timer, instantiated only under FRAME_TIMEOUT_EN.

Verification
REQ-025 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response.
  16 strobes of bytes 0x00..0x0F -> o_frame_valid one cycle after 16th strobe; sample k = k<<8; o_count 16.
  Frame held, 3 further strobes, no ack -> three o_overrun pulses; o_samples unchanged; o_count 16.
  FULL, ack and strobe of 0xFF in same cycle -> o_frame_valid 0; o_count 1; sample 0 = 0xFF00; no o_overrun.
  FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100, 5 strobes then idle 100 cycles -> o_timeout pulse; o_count 0; next 16 strobes form a full frame.
  Strobe in exactly the timeout cycle -> no o_timeout; o_count increments.
  i_rst during 9th strobe -> o_count 0; o_samples zero; no pulses; next 16 strobes form a full frame.
